// File: rtl/mcp_exec_unit_if.sv
// mcp_exec_unit_if: operand, control and result bundle for the exec unit
interface mcp_exec_unit_if;
   logic [31:0] a_i32;
   logic [31:0] b_i32;
   logic [5:0]  funct_i6;
   logic [1:0]  alt_ctrl_i2;
   logic        en_i;
   logic [31:0] y_o32;
   logic        zero_o;
   logic [31:0] alu_out_o32;
   logic [31:0] held_o32;
   modport master (
      output a_i32, b_i32, funct_i6, alt_ctrl_i2, en_i,
      input  y_o32, zero_o, alu_out_o32, held_o32
   );
   modport slave (
      input  a_i32, b_i32, funct_i6, alt_ctrl_i2, en_i,
      output y_o32, zero_o, alu_out_o32, held_o32
   );
endinterface

// File: rtl/mcp_exec_unit.sv
// mcp_exec_unit: MIPS-style 32-bit ALU with a free-running result register
// and an enable-gated held-result register.
module mcp_exec_unit (
   input  logic             clk_i,
   input  logic             reset_i,
   mcp_exec_unit_if.slave   bus
);
   logic [31:0] a, b, y;
   logic        slt, sltu;
   assign a    = bus.a_i32;
   assign b    = bus.b_i32;
   // $signed compare stays correct where a - b would overflow
   assign slt  = $signed(a) < $signed(b);
   assign sltu = a < b;
   always_comb begin
      y = '0;
      case (bus.alt_ctrl_i2)
         2'b00: y = a + b;
         2'b01: y = a - b;
         2'b11: y = {31'b0, slt};
         default:
            case (bus.funct_i6)
               6'b100000, 6'b100001: y = a + b;
               6'b100010, 6'b100011: y = a - b;
               6'b100100: y = a & b;
               6'b100101: y = a | b;
               6'b100110: y = a ^ b;
               6'b100111: y = ~(a | b);
               6'b101010: y = {31'b0, slt};
               6'b101011: y = {31'b0, sltu};
               default:   y = '0;
            endcase
      endcase
   end
   assign bus.y_o32  = y;
   assign bus.zero_o = y == '0;
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         bus.alu_out_o32 <= '0;
         bus.held_o32    <= '0;
      end else begin
         bus.alu_out_o32 <= y;
         if (bus.en_i) bus.held_o32 <= y;
      end
   end
endmodule

// File: tb/tb_mcp_exec_unit.sv
// tb_mcp_exec_unit: scoreboard bench; stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_mcp_exec_unit;
   logic clk_i = 1'b0;
   logic reset_i = 1'b1;
   always #5 clk_i = ~clk_i;
   mcp_exec_unit_if bus ();
   mcp_exec_unit dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));

   typedef struct {
      string       name;
      logic [31:0] y;
      logic        zero;
      logic [31:0] alu;
      logic [31:0] held;
   } exp_t;
   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   logic [31:0] m_alu = '0, m_held = '0, p_y = '0;
   logic        p_en = 1'b0, p_rst = 1'b1;

   localparam logic [5:0] FUNCTS [12] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b111111};

   function automatic logic [31:0] ref_y(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] f, input logic [1:0] alt);
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint m = 64'h1_0000_0000;
      int sa = int'(a);
      int sb_ = int'(b);
      if (alt == 2'b00) return 32'((ua + ub) % m);
      if (alt == 2'b01) return 32'((ua + m - ub) % m);
      if (alt == 2'b11) return (sa < sb_) ? 32'd1 : 32'd0;
      case (f)
         6'b100000, 6'b100001: return 32'((ua + ub) % m);
         6'b100010, 6'b100011: return 32'((ua + m - ub) % m);
         6'b100100: return a & b;
         6'b100101: return a | b;
         6'b100110: return a ^ b;
         6'b100111: return ~(a | b);
         6'b101010: return (sa < sb_) ? 32'd1 : 32'd0;
         6'b101011: return (ua < ub) ? 32'd1 : 32'd0;
         default:   return 32'd0;
      endcase
   endfunction

   task automatic cyc(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                      input logic [1:0] alt, input logic en, input logic rst, input string name);
      exp_t e;
      logic [31:0] y;
      @(posedge clk_i);
      #1;
      if (p_rst) begin
         m_alu = '0;
         m_held = '0;
      end else begin
         m_alu = p_y;
         if (p_en) m_held = p_y;
      end
      bus.a_i32 = a;
      bus.b_i32 = b;
      bus.funct_i6 = f;
      bus.alt_ctrl_i2 = alt;
      bus.en_i = en;
      reset_i = rst;
      y = ref_y(a, b, f, alt);
      if (rst) begin
         m_alu = '0;
         m_held = '0;
      end
      e.name = name;
      e.y = y;
      e.zero = (y == 32'd0);
      e.alu = m_alu;
      e.held = m_held;
      sb.push_back(e);
      p_y = y;
      p_en = en;
      p_rst = rst;
   endtask

   task automatic chk(input string name, input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %h expected %h", name, what, act, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk(e.name, "y", bus.y_o32, e.y);
         chk(e.name, "zero", {31'b0, bus.zero_o}, {31'b0, e.zero});
         chk(e.name, "alu_out", bus.alu_out_o32, e.alu);
         chk(e.name, "held", bus.held_o32, e.held);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, b;
      bus.a_i32 = '0;
      bus.b_i32 = '0;
      bus.funct_i6 = '0;
      bus.alt_ctrl_i2 = '0;
      bus.en_i = 1'b0;
      cyc(32'd3, 32'd4, 6'd0, 2'b00, 1'b1, 1'b1, "reset_state");
      cyc(32'd5, 32'd7, 6'd0, 2'b00, 1'b0, 1'b0, "add_5_7");
      cyc(32'd9, 32'd9, 6'd0, 2'b01, 1'b0, 1'b0, "sub_zero");
      cyc(32'd0, 32'd1, 6'd0, 2'b01, 1'b0, 1'b0, "sub_wrap");
      cyc(32'hF0F0F0F0, 32'h0FF00FF0, 6'b100100, 2'b10, 1'b0, 1'b0, "and");
      cyc(32'hF0F0F0F0, 32'h0FF00FF0, 6'b100101, 2'b10, 1'b0, 1'b0, "or");
      cyc(32'hF0F0F0F0, 32'h0FF00FF0, 6'b100110, 2'b10, 1'b0, 1'b0, "xor");
      cyc(32'hF0F0F0F0, 32'h0FF00FF0, 6'b100111, 2'b10, 1'b0, 1'b0, "nor");
      cyc(32'hF0F0F0F0, 32'h0FF00FF0, 6'b000000, 2'b10, 1'b0, 1'b0, "undef_funct");
      cyc(32'hFFFFFFFF, 32'd1, 6'b101010, 2'b10, 1'b0, 1'b0, "slt_neg");
      cyc(32'hFFFFFFFF, 32'd1, 6'b101011, 2'b10, 1'b0, 1'b0, "sltu_big");
      cyc(32'h7FFFFFFF, 32'h80000000, 6'b101010, 2'b10, 1'b0, 1'b0, "slt_ovf");
      cyc(32'h7FFFFFFF, 32'h80000000, 6'd0, 2'b11, 1'b0, 1'b0, "alt11_ovf");
      cyc(32'h7FFFFFFF, 32'd1, 6'd0, 2'b00, 1'b0, 1'b0, "add_ovf_wrap");
      cyc(32'h1234, 32'd0, 6'd0, 2'b00, 1'b1, 1'b0, "held_load");
      for (int i = 0; i < 3; i++) cyc(32'h5678, 32'd0, 6'd0, 2'b00, 1'b0, 1'b0, "held_keep");
      cyc(32'h5678, 32'd0, 6'd0, 2'b00, 1'b1, 1'b1, "reset_mid");
      cyc(32'h9, 32'd0, 6'd0, 2'b00, 1'b1, 1'b1, "reset_hold");
      cyc(32'hA, 32'd0, 6'd0, 2'b00, 1'b1, 1'b0, "reset_release");
      cyc(32'hB, 32'd0, 6'd0, 2'b00, 1'b0, 1'b0, "first_capture");
      for (int i = 0; i < 400; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: a = b;
            1: a = 32'h7FFFFFFF;
            2: b = 32'h80000000;
            default: ;
         endcase
         cyc(a, b, FUNCTS[$urandom_range(0, 11)], 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0, "random");
      end
      repeat (2) @(posedge clk_i);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
